// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: serial audio playback engine fetching words over req/data_ready with a one-word prefetch buffer.
// Define AUDIO_LOOP_EN to honour the loop input (continuous replay of the start..stop range).
module audio_stream_ctrl #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int BIT_DIV   = 79,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic              loop,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              data_ready,
    output logic              data,
    output logic              bit_strobe,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              NC,
    output logic              gain,
    output logic              stop
);
    localparam int DW = $clog2(BIT_DIV);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, FETCH, PLAY, STALL, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] start_r, stop_r;
    logic              loop_r, more, buf_valid;
    logic [DATA_W-1:0] sh, buf_word;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              got, at_end, load_now, nxt_ok;
    logic [DATA_W-1:0] ld_word, sh_nxt;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST != 0 ? w[DATA_W-1] : w[0];
    endfunction

    assign got      = req & data_ready;
    assign at_end   = state == PLAY && div_cnt == DW'(BIT_DIV - 1) && bit_cnt == BW'(DATA_W - 1);
    // A word arriving exactly on the boundary goes straight to the shifter instead of reporting underrun
    assign load_now = (got && (state == FETCH || state == STALL)) || (at_end && (buf_valid || got));
    assign ld_word  = buf_valid ? buf_word : mem_data;
    assign sh_nxt   = MSB_FIRST != 0 ? sh << 1 : sh >> 1;
    // Compare one bit wider so stop_addr at the top of the address space never wraps
    assign nxt_ok   = ({1'b0, addr} + (ADDR_W+1)'(1)) <= {1'b0, stop_r};
    assign busy     = state == FETCH || state == PLAY || state == STALL;
    assign NC       = 1'b0;
    assign gain     = 1'b0;
    assign stop     = 1'b0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            req        <= 1'b0;
            addr       <= '0;
            data       <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            buf_valid  <= 1'b0;
            more       <= 1'b0;
            start_r    <= '0;
            stop_r     <= '0;
            loop_r     <= 1'b0;
            sh         <= '0;
            buf_word   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
        end else if (abort) begin
            state      <= IDLE;
            req        <= 1'b0;
            data       <= 1'b0;
            bit_strobe <= 1'b0;
            buf_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            if (got) begin
                req  <= 1'b0;
                more <= nxt_ok | loop_r;
                addr <= nxt_ok ? addr + ADDR_W'(1) : (loop_r ? start_r : addr);
            end else if ((state == PLAY || state == STALL) && more && !buf_valid) begin
                req <= 1'b1;
            end
            if (state == PLAY && got && !at_end) begin
                buf_word  <= mem_data;
                buf_valid <= 1'b1;
            end
            if (load_now) begin
                sh         <= ld_word;
                data       <= first_bit(ld_word);
                bit_strobe <= 1'b1;
                div_cnt    <= '0;
                bit_cnt    <= '0;
                buf_valid  <= 1'b0;
                state      <= PLAY;
            end else begin
                case (state)
                    IDLE, DONE: if (start) begin
                        start_r  <= start_addr;
                        stop_r   <= stop_addr;
`ifdef AUDIO_LOOP_EN
                        loop_r   <= loop;
`else
                        loop_r   <= loop & 1'b0;
`endif
                        done     <= start_addr > stop_addr;
                        underrun <= 1'b0;
                        if (start_addr > stop_addr) begin
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                            req   <= 1'b1;
                            addr  <= start_addr;
                            more  <= 1'b1;
                        end
                    end
                    PLAY: if (div_cnt != DW'(BIT_DIV - 1)) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else if (bit_cnt != BW'(DATA_W - 1)) begin
                        div_cnt    <= '0;
                        bit_cnt    <= bit_cnt + BW'(1);
                        sh         <= sh_nxt;
                        data       <= first_bit(sh_nxt);
                        bit_strobe <= 1'b1;
                    end else if (more) begin
                        underrun <= 1'b1;
                        state    <= STALL;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        data  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// tb_audio_stream_ctrl: directed bench with a stream-level model (expected fetch order and bit sequence).
module tb_audio_stream_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int BD = 4;

    logic          clk = 1'b0, clr = 1'b1, start = 1'b0, abort = 1'b0, loop = 1'b0, data_ready = 1'b0;
    logic [AW-1:0] start_addr = '0, stop_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          req, data, bit_strobe, busy, done, underrun, NC, gain, stop;
    logic [AW-1:0] addr;

    audio_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BIT_DIV(BD), .MSB_FIRST(0)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .start_addr(start_addr),
        .stop_addr(stop_addr), .loop(loop), .req(req), .addr(addr), .mem_data(mem_data),
        .data_ready(data_ready), .data(data), .bit_strobe(bit_strobe), .busy(busy),
        .done(done), .underrun(underrun), .NC(NC), .gain(gain), .stop(stop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [DW-1:0] mem [16];
    bit exp_bits[$];
    int exp_addr[$];
    int test_id = 0, cur_s = 0, cur_e = 0, st_cyc = 0;
    int stall_idx = -1, stall_len = 0;
    bit allow_gap = 1'b0;
    int strobes = 0, first_cyc = -1, last_cyc = 0, done_cyc = -1, fetches = 0;
    logic [DW-1:0] seq_word = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: expected fetch order and LSB-first bit stream of the requested range
    task automatic plan(input int s, input int e, input int reps);
        exp_bits.delete();
        exp_addr.delete();
        cur_s = s;
        cur_e = e;
        for (int r = 0; r < reps; r++)
            for (int a = s; a <= e; a++) begin
                exp_addr.push_back(a);
                for (int b = 0; b < DW; b++) exp_bits.push_back(mem[a][b]);
            end
        test_id++;
    endtask

    task automatic run(input int s, input int e);
        @(negedge clk);
        start_addr = AW'(s);
        stop_addr  = AW'(e);
        start      = 1'b1;
        st_cyc     = cyc;
        @(negedge clk);
        start = 1'b0;
        if (s <= e) begin
            chk("start_req", req, 1);
            chk("start_addr", addr, s);
            chk("start_busy", busy, 1);
        end else begin
            chk("empty_done", done, 1);
            chk("empty_req", req, 0);
            chk("empty_busy", busy, 0);
        end
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic wait_strobes(input int cnt, input int maxc);
        int n = 0;
        while (strobes < cnt && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("strobe_timeout", strobes >= cnt, 1);
    endtask

    // Memory responder: zero wait states except a programmable stall on one fetch
    initial begin
        int wcnt = 0, rid = 0;
        forever begin
            @(negedge clk);
            if (rid != test_id) begin
                fetches = 0;
                rid = test_id;
            end
            if (data_ready) data_ready = 1'b0;
            else if (req && clr) begin
                if (wcnt < (fetches == stall_idx ? stall_len : 0)) wcnt++;
                else begin
                    wcnt = 0;
                    mem_data = mem[addr];
                    data_ready = 1'b1;
                    if (exp_addr.size() == 0) chk("extra_fetch", addr, -1);
                    else chk("fetch_addr", addr, exp_addr.pop_front());
                    fetches++;
                end
            end else wcnt = 0;
        end
    end

    // Compare process: every cycle after the active edge
    initial begin
        int seen = 0;
        logic prev_data = 1'b0, prev_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (seen != test_id) begin
                strobes = 0;
                first_cyc = -1;
                done_cyc = -1;
                seq_word = '0;
                seen = test_id;
            end
            if (clr) begin
                if (bit_strobe) begin
                    if (exp_bits.size() == 0) chk("extra_bit", strobes, -1);
                    else chk("bit", data, exp_bits.pop_front());
                    if (strobes < DW) seq_word[strobes] = data;
                    if (strobes == 0) first_cyc = cyc;
                    else if (allow_gap) chk("gap_min", (cyc - last_cyc) >= BD, 1);
                    else chk("gap", cyc - last_cyc, BD);
                    last_cyc = cyc;
                    strobes++;
                end else if (busy) chk("hold", data, prev_data);
                if (done && !prev_done) begin
                    done_cyc = cyc;
                    chk("done_all_played", exp_bits.size(), 0);
                end
                if (req) chk("addr_in_range", int'(addr) >= cur_s && int'(addr) <= cur_e, 1);
                prev_data = data;
                prev_done = done;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i * 37 + 11);
        mem[0] = 8'h96;
        mem[1] = 8'h3C;
        mem[5] = 8'hA5;
        #2 clr = 1'b0;
        #10;
        chk("rst_addr", addr, 0);
        chk("rst_req", req, 0);
        chk("rst_data", data, 0);
        chk("rst_strobe", bit_strobe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_tied", {NC, gain, stop}, 0);
        @(negedge clk) clr = 1'b1;

        // single word 0xA5 at address 5
        plan(5, 5, 1);
        run(5, 5);
        wait_done(200);
        chk("single_fetches", fetches, 1);
        chk("single_word", seq_word, 8'hA5);
        chk("single_done_after_capture", done_cyc - first_cyc, 32);
        chk("single_data_low", data, 0);

        // gap-free stream 0..3
        plan(0, 3, 1);
        run(0, 3);
        wait_done(400);
        chk("stream_latency", first_cyc - (st_cyc + 1), 1);
        chk("stream_strobes", strobes, 32);
        chk("stream_underrun", underrun, 0);
        chk("stream_addr", addr, 3);

        // underrun on the second fetch
        plan(0, 1, 1);
        allow_gap = 1'b1;
        stall_idx = 1;
        stall_len = 40;
        run(0, 1);
        begin
            int n = 0;
            while (!underrun && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("underrun_set", underrun, 1);
        chk("underrun_hold_bit7", data, mem[0][7]);
        chk("underrun_busy", busy, 1);
        wait_done(400);
        chk("underrun_strobes", strobes, 16);
        chk("underrun_sticky", underrun, 1);
        allow_gap = 1'b0;
        stall_idx = -1;

        // abort mid-word 2, then abort and start together
        plan(0, 3, 1);
        run(0, 3);
        wait_strobes(20, 400);
        @(negedge clk) abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_req", req, 0);
        chk("abort_data", data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        start_addr = 0;
        stop_addr = 3;
        start = 1'b1;
        @(posedge clk); #1;
        chk("abort_wins_busy", busy, 0);
        chk("abort_wins_req", req, 0);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;

        // empty range
        plan(9, 3, 1);
        run(9, 3);
        repeat (10) @(negedge clk);
        chk("empty_fetches", fetches, 0);

        // asynchronous reset mid-play
        plan(0, 3, 1);
        run(0, 3);
        wait_strobes(10, 400);
        @(posedge clk); #3 clr = 1'b0;
        #1;
        chk("areset_outputs", {req, addr, data, bit_strobe, busy, done, underrun}, 0);
        @(negedge clk) clr = 1'b1;

        // top of address range
        plan(14, 15, 1);
        run(14, 15);
        wait_done(300);
        chk("top_fetches", fetches, 2);
        chk("top_strobes", strobes, 16);
        chk("top_addr", addr, 15);

        // loop request on range 2..3
        loop = 1'b1;
`ifdef AUDIO_LOOP_EN
        plan(2, 3, 4);
        run(2, 3);
        wait_strobes(40, 600);
        chk("loop_done_low", done, 0);
        chk("loop_fetches", fetches >= 5, 1);
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
`else
        plan(2, 3, 1);
        run(2, 3);
        wait_done(300);
        chk("noloop_fetches", fetches, 2);
        chk("noloop_strobes", strobes, 16);
`endif
        loop = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
